// File: rtl/can_tx_sequencer.sv
// can_tx_sequencer
//   Avalon-MM master that sends one standard CAN frame through the BasicCAN
//   register port: polls the status register for TBS, loads the TX
//   buffer (ID1, ID2, data bytes), issues the transmission request and polls
//   for TCS. Completion is reported with one-cycle tx_done / tx_err pulses.
//
// Ports
//   av_clk, av_reset        clock, synchronous active-high reset
//   tx_req                  frame request, sampled only while idle
//   tx_id/tx_rtr/tx_dlc     frame header (11-bit ID, remote flag, length)
//   tx_data                 data bytes, byte0 = tx_data[7:0]
//   tx_busy                 sequence in progress
//   tx_done / tx_err        one-cycle completion pulses
//   err_code                1=TBS timeout, 2=TCS timeout, 3=bus timeout/abort
//   m_*                     Avalon-MM master (registered strobes)
//   tx_abort                only when CAN_TX_ABORT_EN is defined
//
// Optional feature macro: CAN_TX_ABORT_EN (abort request during polling).
module can_tx_sequencer #(
  parameter int unsigned POLL_LIMIT  = 1024,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic        av_clk,
  input  logic        av_reset,
  input  logic        tx_req,
  input  logic [10:0] tx_id,
  input  logic        tx_rtr,
  input  logic [3:0]  tx_dlc,
  input  logic [63:0] tx_data,
`ifdef CAN_TX_ABORT_EN
  input  logic        tx_abort,
`endif
  output logic        tx_busy,
  output logic        tx_done,
  output logic        tx_err,
  output logic [1:0]  err_code,
  output logic [7:0]  m_address,
  output logic        m_chipselect,
  output logic        m_read,
  output logic        m_write,
  output logic [7:0]  m_writedata,
  input  logic [7:0]  m_readdata,
  input  logic        m_waitrequest_n
);

  localparam int unsigned POLL_W = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT) : 1;
  localparam int unsigned WAIT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_LIMIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_POLL_TBS,
    S_WR_ID1,
    S_WR_ID2,
    S_WR_DATA,
    S_WR_CMD,
    S_POLL_TCS,
    S_WR_ABORT,
    S_DONE,
    S_ERR
  } state_e;

  // Every bus-using state walks the same three phases: issue the registered
  // strobe, hold it until ack, then spend the idle gap cycle deciding the
  // next state from the captured read data.
  typedef enum logic [1:0] {
    BUS_IDLE,
    BUS_BUSY,
    BUS_ACKED
  } bus_e;

  state_e            state_q, state_d;
  bus_e              bus_q, bus_d;
  logic [10:0]       id_q, id_d;
  logic              rtr_q, rtr_d;
  logic [3:0]        dlc_q, dlc_d;
  logic [63:0]       data_q, data_d;
  logic [3:0]        nbytes_q, nbytes_d;
  logic [2:0]        idx_q, idx_d;
  logic [POLL_W-1:0] poll_cnt_q, poll_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]        status_q, status_d;   // {TCS, TBS} from last read
  logic [1:0]        err_code_q, err_code_d;
  logic [7:0]        m_address_q, m_address_d;
  logic [7:0]        m_writedata_q, m_writedata_d;
  logic              m_read_q, m_read_d;
  logic              m_write_q, m_write_d;
`ifdef CAN_TX_ABORT_EN
  logic              abort_pend_q, abort_pend_d;
`endif

  logic              acc_wr;
  logic [7:0]        acc_addr;
  logic [7:0]        acc_data;

  // Only the TBS and TCS status bits matter to the sequence.
  logic rd_unused;
  assign rd_unused = ^{m_readdata[7:4], m_readdata[1:0]};

  always_comb begin
    state_d       = state_q;
    bus_d         = bus_q;
    id_d          = id_q;
    rtr_d         = rtr_q;
    dlc_d         = dlc_q;
    data_d        = data_q;
    nbytes_d      = nbytes_q;
    idx_d         = idx_q;
    poll_cnt_d    = poll_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    status_d      = status_q;
    err_code_d    = err_code_q;
    m_address_d   = m_address_q;
    m_writedata_d = m_writedata_q;
    m_read_d      = m_read_q;
    m_write_d     = m_write_q;
`ifdef CAN_TX_ABORT_EN
    abort_pend_d  = abort_pend_q;
`endif

    acc_wr   = 1'b0;
    acc_addr = '0;
    acc_data = '0;
    case (state_q)
      S_POLL_TBS, S_POLL_TCS: begin
        acc_addr = 8'd2;
      end
      S_WR_ID1: begin
        acc_wr   = 1'b1;
        acc_addr = 8'd10;
        acc_data = id_q[10:3];
      end
      S_WR_ID2: begin
        acc_wr   = 1'b1;
        acc_addr = 8'd11;
        acc_data = {id_q[2:0], rtr_q, dlc_q};
      end
      S_WR_DATA: begin
        acc_wr   = 1'b1;
        acc_addr = 8'd12 + {5'd0, idx_q};
        acc_data = data_q[{idx_q, 3'b000} +: 8];
      end
      S_WR_CMD: begin
        acc_wr   = 1'b1;
        acc_addr = 8'd1;
        acc_data = 8'h01;
      end
      S_WR_ABORT: begin
        acc_wr   = 1'b1;
        acc_addr = 8'd1;
        acc_data = 8'h02;
      end
      default: ;
    endcase

    case (state_q)
      S_IDLE: begin
        if (tx_req) begin
          id_d       = tx_id;
          rtr_d      = tx_rtr;
          dlc_d      = tx_dlc;
          data_d     = tx_data;
          nbytes_d   = tx_rtr ? 4'd0 : ((tx_dlc > 4'd8) ? 4'd8 : tx_dlc);
          poll_cnt_d = '0;
          bus_d      = BUS_IDLE;
          state_d    = S_POLL_TBS;
        end
      end
      S_DONE, S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        case (bus_q)
          BUS_IDLE: begin
            m_read_d      = ~acc_wr;
            m_write_d     = acc_wr;
            m_address_d   = acc_addr;
            m_writedata_d = acc_data;
            wait_cnt_d    = '0;
            bus_d         = BUS_BUSY;
          end
          BUS_BUSY: begin
            if (m_waitrequest_n) begin
              m_read_d  = 1'b0;
              m_write_d = 1'b0;
              status_d  = {m_readdata[3], m_readdata[2]};
              bus_d     = BUS_ACKED;
            end else if (wait_cnt_q == WAIT_LAST) begin
              m_read_d   = 1'b0;
              m_write_d  = 1'b0;
              bus_d      = BUS_IDLE;
              state_d    = S_ERR;
              err_code_d = 2'd3;
            end else begin
              wait_cnt_d = wait_cnt_q + 1'b1;
            end
          end
          default: begin
            bus_d = BUS_IDLE;
            case (state_q)
              S_POLL_TBS: begin
                if (status_q[0]) begin
                  state_d = S_WR_ID1;
                end else if (poll_cnt_q == POLL_LAST) begin
                  state_d    = S_ERR;
                  err_code_d = 2'd1;
                end else begin
                  poll_cnt_d = poll_cnt_q + 1'b1;
                end
              end
              S_WR_ID1: state_d = S_WR_ID2;
              S_WR_ID2: begin
                idx_d   = '0;
                state_d = (nbytes_q == 4'd0) ? S_WR_CMD : S_WR_DATA;
              end
              S_WR_DATA: begin
                if (({1'b0, idx_q} + 4'd1) == nbytes_q) begin
                  state_d = S_WR_CMD;
                end else begin
                  idx_d = idx_q + 1'b1;
                end
              end
              S_WR_CMD: begin
                poll_cnt_d = '0;
                state_d    = S_POLL_TCS;
              end
              S_POLL_TCS: begin
                if (status_q[1]) begin
                  state_d = S_DONE;
                end else if (poll_cnt_q == POLL_LAST) begin
                  state_d    = S_ERR;
                  err_code_d = 2'd2;
                end else begin
                  poll_cnt_d = poll_cnt_q + 1'b1;
                end
              end
              S_WR_ABORT: begin
                state_d    = S_ERR;
                err_code_d = 2'd3;
              end
              default: ;
            endcase
          end
        endcase
      end
    endcase

`ifdef CAN_TX_ABORT_EN
    // An abort seen mid-access is remembered and acted on once the access
    // has completed; with no access outstanding it takes over immediately,
    // cancelling whatever the poll state would otherwise have done.
    if (state_q == S_POLL_TBS || state_q == S_POLL_TCS) begin
      if (bus_q == BUS_BUSY) begin
        if (tx_abort) begin
          abort_pend_d = 1'b1;
        end
      end else if (tx_abort || abort_pend_q) begin
        state_d       = S_WR_ABORT;
        bus_d         = BUS_IDLE;
        abort_pend_d  = 1'b0;
        m_read_d      = 1'b0;
        m_write_d     = 1'b0;
        m_address_d   = m_address_q;
        m_writedata_d = m_writedata_q;
        poll_cnt_d    = poll_cnt_q;
        err_code_d    = err_code_q;
      end
    end
    if (state_q == S_IDLE) begin
      abort_pend_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge av_clk) begin
    if (av_reset) begin
      state_q       <= S_IDLE;
      bus_q         <= BUS_IDLE;
      id_q          <= '0;
      rtr_q         <= 1'b0;
      dlc_q         <= '0;
      data_q        <= '0;
      nbytes_q      <= '0;
      idx_q         <= '0;
      poll_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      status_q      <= '0;
      err_code_q    <= '0;
      m_address_q   <= '0;
      m_writedata_q <= '0;
      m_read_q      <= 1'b0;
      m_write_q     <= 1'b0;
`ifdef CAN_TX_ABORT_EN
      abort_pend_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      bus_q         <= bus_d;
      id_q          <= id_d;
      rtr_q         <= rtr_d;
      dlc_q         <= dlc_d;
      data_q        <= data_d;
      nbytes_q      <= nbytes_d;
      idx_q         <= idx_d;
      poll_cnt_q    <= poll_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      status_q      <= status_d;
      err_code_q    <= err_code_d;
      m_address_q   <= m_address_d;
      m_writedata_q <= m_writedata_d;
      m_read_q      <= m_read_d;
      m_write_q     <= m_write_d;
`ifdef CAN_TX_ABORT_EN
      abort_pend_q  <= abort_pend_d;
`endif
    end
  end

  assign tx_busy      = (state_q != S_IDLE);
  assign tx_done      = (state_q == S_DONE);
  assign tx_err       = (state_q == S_ERR);
  assign err_code     = err_code_q;
  assign m_address    = m_address_q;
  assign m_writedata  = m_writedata_q;
  assign m_read       = m_read_q;
  assign m_write      = m_write_q;
  assign m_chipselect = m_read_q | m_write_q;

endmodule

// File: tb/tb_can_tx_sequencer.sv
// Self-checking bench for can_tx_sequencer: a responder model acks accesses
// with configurable latency and serves status bytes from a queue; each frame
// is compared against an access list built from the frame contents.
`timescale 1ns/1ps

`define CHECK(TAG, OBS, EXP) \
  begin \
    checks++; \
    assert ((OBS) === (EXP)) else begin \
      errors++; \
      $error("FAIL %s observed=%0h expected=%0h", TAG, (OBS), (EXP)); \
    end \
  end

module tb_can_tx_sequencer;

  localparam int unsigned PL = 24;
  localparam int unsigned AT = 8;

  logic        av_clk = 1'b0;
  logic        av_reset;
  logic        tx_req;
  logic [10:0] tx_id;
  logic        tx_rtr;
  logic [3:0]  tx_dlc;
  logic [63:0] tx_data;
  logic        tx_abort;
  logic        tx_busy, tx_done, tx_err;
  logic [1:0]  err_code;
  logic [7:0]  m_address, m_writedata, m_readdata;
  logic        m_chipselect, m_read, m_write, m_waitrequest_n;

  always #5 av_clk = ~av_clk;

  can_tx_sequencer #(.POLL_LIMIT(PL), .ACK_TIMEOUT(AT)) dut (
    .av_clk          (av_clk),
    .av_reset        (av_reset),
    .tx_req          (tx_req),
    .tx_id           (tx_id),
    .tx_rtr          (tx_rtr),
    .tx_dlc          (tx_dlc),
    .tx_data         (tx_data),
`ifdef CAN_TX_ABORT_EN
    .tx_abort        (tx_abort),
`endif
    .tx_busy         (tx_busy),
    .tx_done         (tx_done),
    .tx_err          (tx_err),
    .err_code        (err_code),
    .m_address       (m_address),
    .m_chipselect    (m_chipselect),
    .m_read          (m_read),
    .m_write         (m_write),
    .m_writedata     (m_writedata),
    .m_readdata      (m_readdata),
    .m_waitrequest_n (m_waitrequest_n)
  );

  int          checks = 0;
  int          errors = 0;
  int          proto_bad = 0;
  int          strobe_cycles = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  logic [1:0]  err_seen = '0;
  logic [1:0]  last_code = '0;
  int          ack_lat = 0;
  bit          never_ack = 1'b0;
  logic [7:0]  status_q[$];
  logic [16:0] log_q[$];
  logic [16:0] exp_q[$];
  int          cmd_pos;

  int          mon_held = 0;
  logic        mon_prev_strobe = 1'b0;
  logic        mon_acked = 1'b0;
  logic [16:0] mon_prev_ent = '0;
  logic [16:0] mon_cur_ent;

  function automatic logic [16:0] ent(input logic we, input logic [7:0] a, input logic [7:0] d);
    return {we, a, d};
  endfunction

  task automatic tick();
    @(posedge av_clk);
    #1;
  endtask

  // Responder and protocol monitor.
  initial begin
    m_waitrequest_n = 1'b0;
    m_readdata      = '0;
    forever begin
      @(posedge av_clk);
      #1;
      mon_cur_ent = {m_write, m_address, m_write ? m_writedata : 8'h00};
      if (m_chipselect !== (m_read | m_write)) proto_bad++;
      if (m_read && m_write) proto_bad++;
      if ((m_read | m_write) && mon_prev_strobe && !mon_acked && (mon_cur_ent !== mon_prev_ent)) proto_bad++;
      if ((m_read | m_write) && mon_acked) proto_bad++;
      if (tx_done && tx_err) proto_bad++;
      if (tx_done) done_cnt++;
      if (tx_err) begin
        err_cnt++;
        err_seen = err_code;
      end
      mon_prev_strobe = m_read | m_write;
      mon_prev_ent    = mon_cur_ent;
      if (m_read | m_write) begin
        strobe_cycles++;
        if (!never_ack && mon_held == ack_lat) begin
          m_waitrequest_n = 1'b1;
          if (m_read && m_address == 8'd2) begin
            if (status_q.size() > 0) m_readdata = status_q.pop_front();
            else m_readdata = 8'h00;
          end else begin
            m_readdata = 8'($urandom);
          end
          log_q.push_back(mon_cur_ent);
          mon_held  = 0;
          mon_acked = 1'b1;
        end else begin
          m_waitrequest_n = 1'b0;
          m_readdata      = 8'($urandom);
          mon_held++;
          mon_acked = 1'b0;
        end
      end else begin
        m_waitrequest_n = 1'b0;
        mon_held        = 0;
        mon_acked       = 1'b0;
      end
    end
  end

  // Reference: the register access list a frame should produce.
  task automatic build_exp(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                           input logic [63:0] data, input int tbs_z, input int tcs_z);
    int nb;
    exp_q.delete();
    cmd_pos = -1;
    for (int i = 0; i < ((tbs_z >= int'(PL)) ? int'(PL) : tbs_z + 1); i++)
      exp_q.push_back(ent(1'b0, 8'd2, 8'h00));
    if (tbs_z >= int'(PL)) return;
    exp_q.push_back(ent(1'b1, 8'd10, id[10:3]));
    exp_q.push_back(ent(1'b1, 8'd11, {id[2:0], rtr, dlc}));
    nb = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    for (int i = 0; i < nb; i++)
      exp_q.push_back(ent(1'b1, 8'(12 + i), data[8*i +: 8]));
    exp_q.push_back(ent(1'b1, 8'd1, 8'h01));
    cmd_pos = exp_q.size();
    for (int i = 0; i < ((tcs_z >= int'(PL)) ? int'(PL) : tcs_z + 1); i++)
      exp_q.push_back(ent(1'b0, 8'd2, 8'h00));
  endtask

  task automatic run_frame(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                           input logic [63:0] data, input int tbs_z, input int tcs_z,
                           input int lat, input bit never, input bit rnd_status, input bit do_abort);
    int   exp_kind;
    int   budget;
    int   busy_gap;
    int   mid_bad;
    int   since_cmd;
    bit   seen;
    bit   cmd_seen;
    bit   abort_fired;
    logic [16:0] last_ent;
    log_q.delete();
    status_q.delete();
    done_cnt = 0;
    err_cnt = 0;
    strobe_cycles = 0;
    proto_bad = 0;
    ack_lat = lat;
    never_ack = never;
    for (int i = 0; i < tbs_z && i < int'(PL); i++)
      status_q.push_back((rnd_status ? 8'($urandom) : 8'h00) & 8'hFB);
    if (tbs_z < int'(PL)) begin
      status_q.push_back(rnd_status ? (8'($urandom) | 8'h04) : 8'h04);
      for (int i = 0; i < tcs_z && i < int'(PL); i++)
        status_q.push_back((rnd_status ? 8'($urandom) : 8'h04) & 8'hF7);
      if (tcs_z < int'(PL))
        status_q.push_back(rnd_status ? (8'($urandom) | 8'h08) : 8'h0C);
    end
    build_exp(id, rtr, dlc, data, tbs_z, tcs_z);
    if (never) exp_q.delete();
    if (never) exp_kind = 3;
    else if (tbs_z >= int'(PL)) exp_kind = 1;
    else if (do_abort) exp_kind = 3;
    else if (tcs_z >= int'(PL)) exp_kind = 2;
    else exp_kind = 0;
    budget = (2 * int'(PL) + 30) * (lat + 4) + 4 * int'(AT) + 100;

    tx_id = id; tx_rtr = rtr; tx_dlc = dlc; tx_data = data; tx_req = 1'b1;
    tick();
    seen = 1'b0; busy_gap = 0; since_cmd = 0; cmd_seen = 1'b0; abort_fired = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (!tx_busy) busy_gap++;
      if (tx_done || tx_err) begin
        seen = 1'b1;
        break;
      end
      // Inputs are scrambled while busy; the frame must stay as latched.
      tx_req  = 1'($urandom);
      tx_id   = 11'($urandom);
      tx_rtr  = 1'($urandom);
      tx_dlc  = 4'($urandom);
      tx_data = {$urandom, $urandom};
      tx_abort = 1'b0;
      if (do_abort && !abort_fired) begin
        if (cmd_seen) begin
          since_cmd++;
          if (since_cmd == 3) begin
            tx_abort = 1'b1;
            abort_fired = 1'b1;
          end
        end else if (log_q.size() > 0) begin
          last_ent = log_q[log_q.size() - 1];
          if (last_ent === ent(1'b1, 8'd1, 8'h01)) cmd_seen = 1'b1;
        end
      end
      tick();
    end
    tx_req = 1'b0;
    tx_abort = 1'b0;
    `CHECK("pulse_seen", seen, 1'b1)
    `CHECK("busy_gap", busy_gap, 0)
    tick();
    `CHECK("busy_after", tx_busy, 1'b0)
    `CHECK("pulse_after", (tx_done | tx_err), 1'b0)
    tick();
    `CHECK("done_cnt", done_cnt, ((exp_kind == 0) ? 1 : 0))
    `CHECK("err_cnt", err_cnt, ((exp_kind != 0) ? 1 : 0))
    if (exp_kind != 0) begin
      `CHECK("err_code", err_seen, exp_kind[1:0])
      last_code = exp_kind[1:0];
    end
    `CHECK("err_code_hold", err_code, last_code)
    `CHECK("protocol", proto_bad, 0)
    if (never) `CHECK("ack_hold_cycles", strobe_cycles, int'(AT))
    if (do_abort) begin
      `CHECK("abort_len", (log_q.size() > cmd_pos), 1'b1)
      if (log_q.size() > cmd_pos) begin
        for (int i = 0; i < cmd_pos; i++)
          `CHECK($sformatf("access%0d", i), log_q[i], exp_q[i])
        mid_bad = 0;
        for (int i = cmd_pos; i < log_q.size() - 1; i++)
          if (log_q[i] !== ent(1'b0, 8'd2, 8'h00)) mid_bad++;
        `CHECK("abort_mid_reads", mid_bad, 0)
        `CHECK("abort_write", log_q[log_q.size() - 1], ent(1'b1, 8'd1, 8'h02))
      end
    end else begin
      `CHECK("access_count", log_q.size(), exp_q.size())
      for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
        `CHECK($sformatf("access%0d", i), log_q[i], exp_q[i])
    end
  endtask

  initial begin
    int          idle_bad;
    int          hi_writes;
    logic [16:0] e;
    logic [10:0] rid;
    av_reset = 1'b1;
    tx_req = 1'b0; tx_id = '0; tx_rtr = 1'b0; tx_dlc = '0; tx_data = '0; tx_abort = 1'b0;
    repeat (3) tick();
    av_reset = 1'b0;
    proto_bad = 0;
    strobe_cycles = 0;
    idle_bad = 0;
    repeat (10) begin
      tick();
      if (tx_busy | tx_done | tx_err | m_read | m_write | m_chipselect |
          (err_code != 2'd0) | (m_address != 8'd0) | (m_writedata != 8'd0)) idle_bad++;
    end
    `CHECK("reset_idle_outputs", idle_bad, 0)
    `CHECK("reset_no_strobes", strobe_cycles, 0)
    `CHECK("reset_busy", tx_busy, 1'b0)

    // Directed frame from the plan.
    run_frame(11'h123, 1'b0, 4'd2, 64'h55AA, 0, 0, 2, 1'b0, 1'b0, 1'b0);
    `CHECK("tp_len", log_q.size(), 7)
    if (log_q.size() == 7) begin
      `CHECK("tp_id1", log_q[1], ent(1'b1, 8'd10, 8'h24))
      `CHECK("tp_id2", log_q[2], ent(1'b1, 8'd11, 8'h62))
      `CHECK("tp_b0",  log_q[3], ent(1'b1, 8'd12, 8'hAA))
      `CHECK("tp_b1",  log_q[4], ent(1'b1, 8'd13, 8'h55))
      `CHECK("tp_cmd", log_q[5], ent(1'b1, 8'd1,  8'h01))
    end

    // Remote frame: no data writes, RTR bit set in ID2.
    rid = 11'($urandom);
    run_frame(rid, 1'b1, 4'd4, {$urandom, $urandom}, 1, 1, 1, 1'b0, 1'b1, 1'b0);
    hi_writes = 0;
    foreach (log_q[i]) begin
      e = log_q[i];
      if (e[16] && e[15:8] >= 8'd12) hi_writes++;
    end
    `CHECK("rtr_no_data", hi_writes, 0)
    if (log_q.size() > 2) begin
      e = log_q[2];
      `CHECK("rtr_bit", e[4], 1'b1)
    end

    for (int f = 0; f < 10; f++)
      run_frame(11'($urandom), 1'($urandom), 4'($urandom), {$urandom, $urandom},
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), 1'b0, 1'b1, 1'b0);

    // Boundaries: last poll read succeeds, polls exhausted, ack never arrives.
    run_frame(11'($urandom), 1'b0, 4'd8, {$urandom, $urandom}, int'(PL) - 1, int'(PL) - 1, 0, 1'b0, 1'b1, 1'b0);
    run_frame(11'($urandom), 1'b0, 4'd12, {$urandom, $urandom}, int'(PL), 0, 1, 1'b0, 1'b1, 1'b0);
    run_frame(11'($urandom), 1'b0, 4'd15, {$urandom, $urandom}, 0, int'(PL), 0, 1'b0, 1'b1, 1'b0);
    run_frame(11'($urandom), 1'b0, 4'd3, {$urandom, $urandom}, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    run_frame(11'($urandom), 1'b0, 4'd1, {$urandom, $urandom}, 0, 0, 2, 1'b0, 1'b1, 1'b0);
`ifdef CAN_TX_ABORT_EN
    run_frame(11'($urandom), 1'b0, 4'd2, {$urandom, $urandom}, 0, int'(PL), 1, 1'b0, 1'b0, 1'b1);
`endif

    // Reset in the middle of a held access.
    log_q.delete();
    status_q.delete();
    ack_lat = 3;
    never_ack = 1'b0;
    done_cnt = 0;
    err_cnt = 0;
    tx_req = 1'b1;
    tick();
    tx_req = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (m_read) break;
      tick();
    end
    `CHECK("rst_strobe_seen", m_read, 1'b1)
    av_reset = 1'b1;
    tick();
    `CHECK("rst_strobe_drop", (m_read | m_write | m_chipselect), 1'b0)
    `CHECK("rst_busy", tx_busy, 1'b0)
    av_reset = 1'b0;
    repeat (4) tick();
    `CHECK("rst_no_pulse", (done_cnt + err_cnt), 0)
    `CHECK("rst_err_code", err_code, 2'd0)

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
